fixed_point_serial_sub: RTL and testbench

FIXED_POINT_SERIAL_SUB -- requirements
Module: fixed_point_serial_sub

---
 rtl/fixed_point_serial_sub.sv | 101 ++++++++++
 tb/tb_fixed_point_serial_sub.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_serial_sub.sv
// Bit-serial two's complement subtractor, one result bit per clock, LSB first.
// Optional saturation on signed overflow; valid/ready handshake on the operands.
module fixed_point_serial_sub #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] VALUE_A_IN,
    input  logic [WIDTH-1:0] VALUE_B_IN,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic [WIDTH-1:0] VALUE_OUT,
    output logic             VALID_OUT,
    output logic             OVERFLOW
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             a_bit;
    logic             nb_bit;
    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] raw;
    logic             ovf;
    logic [WIDTH-1:0] result;

    assign READY_OUT = (state == IDLE) && RSTN;
    assign VALID_OUT = (state == DONE);

    // Subtraction as A + ~B + 1: carry starts at 1, B is inverted bitwise.
    assign a_bit      = a_sh[0];
    assign nb_bit     = ~b_sh[0];
    assign sum_bit    = a_bit ^ nb_bit ^ carry;
    assign carry_next = (a_bit & nb_bit) | (a_bit & carry) | (nb_bit & carry);
    assign raw        = {sum_bit, res_sh[WIDTH-1:1]};

    // On the final bit the shift registers hold the operand sign bits.
    assign ovf    = (a_sh[0] ^ b_sh[0]) & (sum_bit ^ a_sh[0]);
    assign result = (SATURATE && ovf) ? (a_sh[0] ? MIN_NEG : MAX_POS) : raw;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            VALUE_OUT <= '0;
            OVERFLOW  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (VALID_IN) begin
                        a_sh   <= VALUE_A_IN;
                        b_sh   <= VALUE_B_IN;
                        res_sh <= '0;
                        cnt    <= '0;
                        carry  <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= raw;
                    carry  <= carry_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        VALUE_OUT <= result;
                        OVERFLOW  <= ovf;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_serial_sub.sv
// Bench for fixed_point_serial_sub: wrapping and saturating instances share
// stimulus; a queue of expected results is checked against each strobe.
module tb_fixed_point_serial_sub;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e0;
        logic       o0;
        logic [7:0] e1;
        logic       o1;
    } vec_t;

    typedef struct {
        logic [7:0] e0;
        logic       o0;
        logic [7:0] e1;
        logic       o1;
        int         acc;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       valid_in;
    logic       ready0, ready1;
    logic [7:0] value0, value1;
    logic       valid0, valid1;
    logic       ovf0, ovf1;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t e;
    bit   due;
    logic [7:0] h0v, h1v;
    logic       h0o, h1o;
    int   last_push;
    bit   have_prev;
    vec_t tbl[8];
    logic [7:0] edge_vals[5];

    fixed_point_serial_sub #(.WIDTH(8), .SATURATE(1'b0)) dut_wrap (
        .CLK(clk), .RSTN(rstn),
        .VALUE_A_IN(a_in), .VALUE_B_IN(b_in), .VALID_IN(valid_in),
        .READY_OUT(ready0), .VALUE_OUT(value0),
        .VALID_OUT(valid0), .OVERFLOW(ovf0)
    );

    fixed_point_serial_sub #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .CLK(clk), .RSTN(rstn),
        .VALUE_A_IN(a_in), .VALUE_B_IN(b_in), .VALID_IN(valid_in),
        .READY_OUT(ready1), .VALUE_OUT(value1),
        .VALID_OUT(valid1), .OVERFLOW(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        logic [7:0] r;
        r    = a - b;
        v.a  = a;
        v.b  = b;
        v.e0 = r;
        v.o0 = (a[7] != b[7]) && (r[7] != a[7]);
        v.o1 = v.o0;
        v.e1 = v.o0 ? (a[7] ? 8'h80 : 8'h7f) : r;
        return v;
    endfunction

    // Strobe timing, ready, and output hold are all checked every cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            h0v = '0; h0o = 1'b0;
            h1v = '0; h1o = 1'b0;
        end else begin
            due = (q.size() != 0) && (cyc == q[0].acc + 9);
            chk("ready_wrap", ready0, q.size() == 0);
            chk("ready_sat", ready1, q.size() == 0);
            chk("strobe_wrap", valid0, due);
            chk("strobe_sat", valid1, due);
            if (due) begin
                e = q.pop_front();
                h0v = e.e0; h0o = e.o0;
                h1v = e.e1; h1o = e.o1;
            end
            chk("value_wrap", value0, h0v);
            chk("ovf_wrap", ovf0, h0o);
            chk("value_sat", value1, h1v);
            chk("ovf_sat", ovf1, h1o);
        end
    end

    task automatic issue(input vec_t v, input bit hold);
        bit got;
        got = 1'b0;
        valid_in = 1'b1;
        a_in = v.a;
        b_in = v.b;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ready0) begin
                a_in = v.a;
                b_in = v.b;
                #1;
                q.push_back('{e0: v.e0, o0: v.o0, e1: v.e1, o1: v.o1,
                              acc: cyc});
                if (hold && have_prev)
                    chk("accept_period", cyc - last_push, 10);
                last_push = cyc;
                have_prev = hold;
                got = 1'b1;
            end else if (hold) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
        end
        if (!got) chk("issue_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) valid_in = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [7:0] ra, rb;

        tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 8'h02, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 8'hfe, 1'b0, 8'hfe, 1'b0};
        tbl[2] = '{8'h7f, 8'hff, 8'h80, 1'b1, 8'h7f, 1'b1};
        tbl[3] = '{8'h80, 8'h01, 8'h7f, 1'b1, 8'h80, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{8'h00, 8'h80, 8'h80, 1'b1, 8'h7f, 1'b1};
        tbl[6] = '{8'hff, 8'h7f, 8'h80, 1'b0, 8'h80, 1'b0};
        tbl[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        edge_vals = '{8'h00, 8'h01, 8'h7f, 8'h80, 8'hff};
        have_prev = 1'b0;
        last_push = 0;

        rstn = 1'b0;
        valid_in = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value_wrap", value0, 0);
        chk("rst_ovf_wrap", ovf0, 0);
        chk("rst_valid_wrap", valid0, 0);
        chk("rst_ready_wrap", ready0, 0);
        chk("rst_value_sat", value1, 0);
        chk("rst_valid_sat", valid1, 0);
        rstn = 1'b1;
        #1;
        chk("ready_after_rst", ready0, 1);

        for (int i = 0; i < 8; i++) issue(tbl[i], 1'b0);

        // Valid held high with operands scrambled while busy.
        have_prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            v = model(8'($urandom), 8'($urandom));
            issue(v, 1'b1);
        end
        valid_in = 1'b0;
        have_prev = 1'b0;

        // Reset during the fourth busy cycle discards the operation.
        issue(model(8'h40, 8'hc0), 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_value_wrap", value0, 0);
        chk("midrst_ovf_wrap", ovf0, 0);
        chk("midrst_valid_wrap", valid0, 0);
        chk("midrst_value_sat", value1, 0);
        chk("midrst_ovf_sat", ovf1, 0);
        chk("midrst_ready", ready0, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("ready_after_midrst", ready0, 1);
        chk("ready_after_midrst_sat", ready1, 1);
        issue(model(8'h7f, 8'hfe), 1'b0);

        for (int i = 0; i < 1500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra = edge_vals[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) rb = edge_vals[$urandom_range(0, 4)];
            issue(model(ra, rb), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        valid_in = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
